// File: rtl/fv_credit_sender.sv
// Transmitter end of a credit-based link. It forwards ready/valid beats with one
// registered cycle of latency and spends one credit per beat. FV_CREDIT_SENDER_ASSERT_EN enables protocol assertions.
module fv_credit_sender #(
  parameter  int MaxCredit    = 4,
  parameter  int DataWidth    = 4,
  parameter  int CreditBypass = 0,
  localparam int CountWidth   = $clog2(MaxCredit + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DataWidth-1:0]  push_data,
  input  logic [CountWidth-1:0] credit_initial,
  input  logic                  credit_return,
  output logic                  out_valid,
  output logic [DataWidth-1:0]  out_data,
  output logic [CountWidth-1:0] credit_count,
  output logic                  credit_available
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam logic [CountWidth:0]   MaxWide   = (CountWidth + 1)'(MaxCredit);
  localparam logic [CountWidth-1:0] MaxNarrow = CountWidth'(MaxCredit);

  state_e                state_q, state_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  out_valid_q;
  logic [DataWidth-1:0]  out_data_q;
  logic                  hs;
  logic [CountWidth:0]   init_wide;
  logic [CountWidth:0]   sum_wide;

  // push_ready depends only on state, held count and the return pulse, never on push_valid.
  always_comb begin
    push_ready = 1'b0;
    if (state_q == ST_ACTIVE) begin
      push_ready = (count_q != '0) || ((CreditBypass != 0) && credit_return);
    end
  end

  assign hs = push_valid & push_ready;

  // Count arithmetic is one bit wider than the counter so that a return at
  // MaxCredit is detected and saturated rather than wrapped.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    init_wide = '0;
    sum_wide  = '0;
    unique case (state_q)
      ST_RESET: begin
        state_d = ST_INIT;
      end
      ST_INIT: begin
        state_d   = ST_ACTIVE;
        init_wide = ({1'b0, credit_initial} > MaxWide) ? MaxWide : {1'b0, credit_initial};
        sum_wide  = init_wide + (CountWidth + 1)'(credit_return);
        count_d   = (sum_wide > MaxWide) ? MaxNarrow : sum_wide[CountWidth-1:0];
      end
      ST_ACTIVE: begin
        sum_wide = {1'b0, count_q} + (CountWidth + 1)'(credit_return)
                 - (CountWidth + 1)'(hs);
        count_d  = (sum_wide > MaxWide) ? MaxNarrow : sum_wide[CountWidth-1:0];
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RESET;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= hs;
      if (hs) begin
        out_data_q <= push_data;
      end
    end
  end

  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign credit_count     = count_q;
  assign credit_available = (count_q != '0);

`ifdef FV_CREDIT_SENDER_ASSERT_EN
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_ACTIVE) |-> (({1'b0, count_q} + (CountWidth + 1)'(credit_return)) <= MaxWide));

  a_init_range: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_INIT) |-> ({1'b0, credit_initial} <= MaxWide));

  a_valid_hold: assert property (@(posedge clk) disable iff (rst)
    (push_valid && !push_ready) |=> push_valid);

  a_data_hold: assert property (@(posedge clk) disable iff (rst)
    (push_valid && !push_ready) |=> $stable(push_data));

  a_spend_legal: assert property (@(posedge clk) disable iff (rst)
    hs |-> ((count_q != '0) || ((CreditBypass != 0) && credit_return)));

  // Not gated by rst: a return while the link is held in reset is the error itself.
  a_no_return_in_reset: assert property (@(posedge clk)
    (state_q == ST_RESET) |-> !credit_return);
`else
  // Assertions are compiled out; the datapath above is unchanged.
`endif

endmodule

// File: doc/fv_credit_sender.md
Name: fv_credit_sender

Overview:
- Formal/sim model of the transmitter end of a credit-based link whose receiver buffers into a FIFO model.
- Accepts upstream ready/valid traffic and forwards each beat downstream with one registered cycle of latency.
- Spends one credit per beat; credits return from the receiver as pulses when it pops.
- Used in FPV environments as the driving side of credit-flow-controlled FIFOs.

Parameters:
- MaxCredit, 4, maximum outstanding credits; must be >= 1.
- DataWidth, 4, payload width; must be >= 1.
- CreditBypass, 0, if 1 a credit returned this cycle may be spent the same cycle.
- CountWidth, $clog2(MaxCredit+1), derived localparam; do not override.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- push_valid  input  1  upstream beat valid.
- push_ready  output  1  upstream beat accepted when push_valid & push_ready.
- push_data  input  DataWidth  upstream payload.
- credit_initial  input  CountWidth  initial credit grant, sampled in INIT; must be <= MaxCredit.
- credit_return  input  1  one-credit return pulse from the receiver.
- out_valid  output  1  downstream beat valid; no backpressure.
- out_data  output  DataWidth  downstream payload.
- credit_count  output  CountWidth  credits currently held.
- credit_available  output  1  credit_count != 0.

Behaviour:
- FSM states:
  - RESET: while rst is high.
  - INIT: exactly one cycle after rst deasserts.
  - ACTIVE: all cycles after INIT; remains ACTIVE until rst.
- Reset values: state=RESET, credit_count=0, out_valid=0, out_data=0, push_ready=0, credit_available=0.
- INIT:
  - credit_count <= credit_initial + credit_return.
  - push_ready=0; no beat is accepted.
- ACTIVE:
  - If CreditBypass=0: push_ready = (credit_count != 0).
  - If CreditBypass=1: push_ready = (credit_count != 0) | credit_return.
  - push_ready is combinational from state, count and credit_return only. It never depends on push_valid.
- Handshake (hs = push_valid & push_ready):
  - out_valid <= hs.
  - out_data <= push_data when hs; otherwise out_data holds.
  - Latency is exactly 1 cycle; output is one beat per cycle maximum.
- Count update in ACTIVE: credit_count <= credit_count + credit_return - hs.
  - Perform the arithmetic in CountWidth+1 bits.
  - Simultaneous return and spend leaves the count unchanged.
  - At count=0, a return plus a spend is legal only when CreditBypass=1; the result is 0.
- Overflow: credit_count + credit_return > MaxCredit is a protocol error. RTL saturates at MaxCredit.
- credit_initial > MaxCredit: RTL clamps to MaxCredit.
- Reset mid-operation:
  - All state returns to reset values asynchronously.
  - In-flight out_valid is dropped.
  - Returns during rst are ignored.
- credit_available mirrors credit_count != 0 and is registered-derived, so no combinational path from inputs.

Optional Feature:
- Macro: FV_CREDIT_SENDER_ASSERT_EN.
- When defined, the following assertions are instantiated:
  - (a) no credit overflow: credit_count + credit_return <= MaxCredit.
  - (b) credit_initial <= MaxCredit during INIT.
  - (c) push_valid & !push_ready |=> push_valid.
  - (d) push_valid & !push_ready |=> $stable(push_data).
  - (e) hs |-> credit_count != 0 or (CreditBypass & credit_return).
  - (f) credit_return never asserted in RESET.
- When undefined: no assertions are compiled. Functional behaviour is identical in both cases.

Test Plan:
- Reset release, credit_initial=3, push_valid held high with data 1,2,3,4 -> INIT cycle with push_ready=0. Then beats 1,2,3 appear on out_valid/out_data one cycle after acceptance, credit_count goes 3,2,1,0. Beat 4 stalls with push_ready=0.
- Count=0, CreditBypass=0, credit_return pulse while push_valid=1 -> no accept that cycle, count becomes 1. The next cycle accepts, count returns to 0.
- Same stimulus with CreditBypass=1 -> accept in the same cycle, count stays 0, out_valid=1 next cycle.
- Count=2 (MaxCredit=4), credit_return and hs together for 5 cycles -> count stays 2, five beats out, one per cycle.
- Count=4 (MaxCredit=4), credit_return=1 with no push -> count saturates at 4. With FV_CREDIT_SENDER_ASSERT_EN defined, the overflow assertion fires.
- rst asserted mid-burst with out_valid=1 and count=2 -> out_valid=0 and count=0 immediately. After release, INIT reloads credit_initial=4 and traffic resumes.
